// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise logic unit with a multi-cycle population count.
// Single-cycle opcodes (and illegal ones) produce a result on the accept edge.
// POPCNT walks operand A one CHUNK-bit slice per cycle before presenting it.
//
// Handshake semantics (both ports):
//   A transfer happens on a rising edge where valid and ready are both 1.
//   in_ready is combinational from state and out_ready; out_valid is 1
//   exactly while a result is held, and out/zero/err stay stable until the
//   result is taken with out_ready=1.
module logic_unit_pipe #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [5:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);
    localparam logic [5:0] OP_POPCNT = 6'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              zero_q, zero_d;
    logic              err_q, err_d;

    logic              accept;
    logic [WIDTH-1:0]  op_res;
    logic              op_illegal;
    logic [31:0]       shamt;
    logic [CHUNK-1:0]  chunk_bits;
    logic [WIDTH-1:0]  chunk_cnt;
    logic [WIDTH-1:0]  acc_sum;

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign out       = out_q;
    assign zero      = zero_q;
    assign err       = err_q;
    assign dbg_state = state_q;

    // Single-cycle opcode decode; anything outside 1..8 (POPCNT handled apart) is illegal.
    always_comb begin
        op_res     = '0;
        op_illegal = 1'b0;
        case (sel)
            6'd1:    op_res = ~A;
            6'd2:    op_res = A | B;
            6'd3:    op_res = A & B;
            6'd4:    op_res = ~(A | B);
            6'd5:    op_res = ~(A & B);
            6'd6:    op_res = A ^ B;
            6'd7:    op_res = ~(A ^ B);
            6'd8:    op_res = A & ~B;
            default: op_illegal = 1'b1;
        endcase
    end

    // Ones count of the slice of the latched operand selected by the chunk index.
    always_comb begin
        shamt      = 32'(idx_q) * 32'(CHUNK);
        chunk_bits = CHUNK'(a_q >> shamt);
        chunk_cnt  = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_cnt = chunk_cnt + WIDTH'(chunk_bits[i]);
        end
        acc_sum = acc_q + chunk_cnt;
    end

    // Next-state and datapath load decisions.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        out_d   = out_q;
        zero_d  = zero_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (sel == OP_POPCNT) begin
                        state_d = S_BUSY;
                        a_d     = A;
                        acc_d   = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = S_DONE;
                        out_d   = op_res;
                        zero_d  = (op_res == '0);
                        err_d   = op_illegal;
                    end
                end else if ((state_q == S_DONE) && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDXW'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    out_d   = acc_sum;
                    zero_d  = (acc_sum == '0);
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            out_q   <= '0;
            zero_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
            zero_q  <= zero_d;
            err_q   <= err_d;
        end
    end

endmodule
